// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage initiator that converts EX/MEM load/store control into a single
//   transaction on the data-memory bus (valid/ready request channel, one-cycle
//   valid response channel).
//   - Stalls the pipeline while a legal access is in flight.
//   - Returns aligned, sign/zero-extended load data as mem_data_mem.
//   - Pulses mem_fault for misaligned or illegal accesses, and for timeouts.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   mem_read_mem/mem_write_mem load / store present in MEM stage
//   funct3_mem                 RV32I load/store width and sign code
//   addr_mem, store_data_mem   effective address, rs2 store value
//   mem_data_mem               registered, extended load result
//   stall_mem                  freeze IF..MEM and MEM/WB enable
//   mem_fault                  one-cycle fault pulse
//   bus_req_*                  request channel (word address, lane-replicated data)
//   bus_rsp_valid/rdata        response / write acknowledge channel
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] store_data_mem,
  output logic [31:0] mem_data_mem,
  output logic        stall_mem,
  output logic        mem_fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Last counter value that is still allowed in REQ/WAIT: the access spends
  // exactly TIMEOUT_CYCLES cycles there before being forced to DONE.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;

  logic acc, ld_f3_ok, st_f3_ok, illegal, misaligned, legal, fault_now, timeout_hit;

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign acc        = mem_read_mem ^ mem_write_mem;
  assign ld_f3_ok   = funct3_mem inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign st_f3_ok   = funct3_mem inside {3'b000, 3'b001, 3'b010};
  assign illegal    = (mem_read_mem & mem_write_mem)
                    | (mem_read_mem & ~mem_write_mem & ~ld_f3_ok)
                    | (mem_write_mem & ~mem_read_mem & ~st_f3_ok);
  assign misaligned = ((funct3_mem[1:0] == 2'b01) & addr_mem[0])
                    | ((funct3_mem[1:0] == 2'b10) & (addr_mem[1:0] != 2'b00));
  assign legal      = acc & ~illegal & ~misaligned;
  // Read+write together is not an access (acc=0) but still has to fault.
  assign fault_now  = (mem_read_mem | mem_write_mem) & ~legal;
  assign timeout_hit = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    data_d  = data_q;
    fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (legal) begin
          state_d = S_REQ;
          we_d    = mem_write_mem;
          addr_d  = {addr_mem[31:2], 2'b00};
          wdata_d = mem_write_mem ? store_wdata(funct3_mem, store_data_mem) : 32'd0;
          be_d    = mem_write_mem ? store_be(funct3_mem, addr_mem[1:0]) : 4'b1111;
          f3_d    = funct3_mem;
          lane_d  = addr_mem[1:0];
        end else if (fault_now) begin
          fault_d = 1'b1;
          data_d  = 32'd0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Timeout takes priority so the REQ/WAIT dwell never exceeds the limit.
        if (timeout_hit) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          data_d  = 32'd0;
        end else if (bus_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving on the last allowed cycle still completes normally.
        if (bus_rsp_valid) begin
          state_d = S_DONE;
          if (!we_q) data_d = load_extract(f3_q, lane_q, bus_rsp_rdata);
        end else if (timeout_hit) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          data_d  = 32'd0;
        end
      end
      S_DONE: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign bus_req_valid = (state_q == S_REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_be    = be_q;
  assign mem_data_mem  = data_q;
  assign mem_fault     = fault_q;
  // Drops in DONE so MEM/WB captures the result on that cycle.
  assign stall_mem     = legal & (state_q != S_DONE);

endmodule
